// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: two writeback sources queued into per-source FIFOs,
// drained round-robin onto the single register file write port.
module rf_write_arbiter #(
   parameter int WORD_SIZE  = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [4:0]           a_rd,
   input  logic [WORD_SIZE-1:0] a_data,
   input  logic                 b_valid,
   output logic                 b_ready,
   input  logic [4:0]           b_rd,
   input  logic [WORD_SIZE-1:0] b_data,
   output logic                 rf_en,
   output logic [4:0]           rf_rd,
   output logic [WORD_SIZE-1:0] rf_data,
   output logic [31:0]          pending
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   logic [4:0]           q_rd   [2][FIFO_DEPTH];
   logic [WORD_SIZE-1:0] q_data [2][FIFO_DEPTH];
   logic [PW-1:0]        wptr   [2];
   logic [PW-1:0]        rptr   [2];
   logic [CW-1:0]        cnt    [2];
   logic                 last_b;

   logic [1:0]           in_valid;
   logic [4:0]           in_rd   [2];
   logic [WORD_SIZE-1:0] in_data [2];
   logic [1:0]           ready;
   logic [1:0]           nempty;
   logic [1:0]           enq;
   logic [1:0]           grant;

   assign in_valid   = {b_valid, a_valid};
   assign in_rd[0]   = a_rd;
   assign in_rd[1]   = b_rd;
   assign in_data[0] = a_data;
   assign in_data[1] = b_data;
   assign a_ready    = ready[0];
   assign b_ready    = ready[1];

   // ready from occupancy only; x0 writes are accepted but dropped
   always_comb begin
      ready  = '0;
      nempty = '0;
      enq    = '0;
      for (int s = 0; s < 2; s++) begin
         nempty[s] = cnt[s] != '0;
         ready[s]  = rst && (cnt[s] != FULL);
         enq[s]    = in_valid[s] && ready[s]
                     && (in_rd[s] != 5'd0);
      end
   end

   // round robin: on a tie the source not granted last wins
   always_comb begin
      grant    = '0;
      grant[0] = nempty[0] && (!nempty[1] || last_b);
      grant[1] = nempty[1] && (!nempty[0] || !last_b);
   end

   // drive the write port from the granted head, zero when idle
   always_comb begin
      rf_en   = |grant;
      rf_rd   = '0;
      rf_data = '0;
      if (grant[0]) begin
         rf_rd   = q_rd[0][rptr[0]];
         rf_data = q_data[0][rptr[0]];
      end else if (grant[1]) begin
         rf_rd   = q_rd[1][rptr[1]];
         rf_data = q_data[1][rptr[1]];
      end
   end

   // OR of destination bits over every live entry, head included
   always_comb begin
      pending = '0;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if ({1'b0, PW'(i) - rptr[s]} < cnt[s])
               pending[q_rd[s][i]] = 1'b1;
         end
      end
      pending[0] = 1'b0;
   end

   // queue pointers, occupancy and arbitration history
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < 2; s++) begin
            wptr[s] <= '0;
            rptr[s] <= '0;
            cnt[s]  <= '0;
         end
         last_b <= 1'b1;
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (enq[s])
               wptr[s] <= wptr[s] + PW'(1);
            if (grant[s])
               rptr[s] <= rptr[s] + PW'(1);
            if (enq[s] && !grant[s])
               cnt[s] <= cnt[s] + CW'(1);
            else if (!enq[s] && grant[s])
               cnt[s] <= cnt[s] - CW'(1);
         end
         if (grant[0])
            last_b <= 1'b0;
         else if (grant[1])
            last_b <= 1'b1;
      end
   end

   // entry storage, validity is tracked by the pointers above
   always_ff @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (enq[s]) begin
            q_rd[s][wptr[s]]   <= in_rd[s];
            q_data[s][wptr[s]] <= in_data[s];
         end
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed and random traffic against a
// queue-based model of the two-source writeback arbiter.
module tb_rf_write_arbiter;

   localparam int W = 32;
   localparam int D = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         a_valid = 1'b0;
   logic         a_ready;
   logic [4:0]   a_rd = '0;
   logic [W-1:0] a_data = '0;
   logic         b_valid = 1'b0;
   logic         b_ready;
   logic [4:0]   b_rd = '0;
   logic [W-1:0] b_data = '0;
   logic         rf_en;
   logic [4:0]   rf_rd;
   logic [W-1:0] rf_data;
   logic [31:0]  pending;

   rf_write_arbiter #(
      .WORD_SIZE (W),
      .FIFO_DEPTH(D)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .a_valid(a_valid),
      .a_ready(a_ready),
      .a_rd   (a_rd),
      .a_data (a_data),
      .b_valid(b_valid),
      .b_ready(b_ready),
      .b_rd   (b_rd),
      .b_data (b_data),
      .rf_en  (rf_en),
      .rf_rd  (rf_rd),
      .rf_data(rf_data),
      .pending(pending)
   );

   // free-running clock
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]   rd;
      logic [W-1:0] data;
   } ent_t;

   ent_t qa[$];
   ent_t qb[$];
   ent_t la[$];
   ent_t lb[$];
   bit   last_b = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_wr = 0;

   function automatic ent_t mk(input logic [4:0] r,
                               input logic [W-1:0] d);
      ent_t e;
      e.rd   = r;
      e.data = d;
      return e;
   endfunction

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   // 0 = A, 1 = B, -1 = nothing queued
   function automatic int model_grant();
      if (qa.size() != 0 && (qb.size() == 0 || last_b))
         return 0;
      if (qb.size() != 0)
         return 1;
      return -1;
   endfunction

   task automatic check_outputs();
      logic [31:0] pend;
      ent_t        h;
      int          g;
      pend = '0;
      foreach (qa[i]) pend[qa[i].rd] = 1'b1;
      foreach (qb[i]) pend[qb[i].rd] = 1'b1;
      pend[0] = 1'b0;
      g = model_grant();
      h = '0;
      if (g == 0) h = qa[0];
      if (g == 1) h = qb[0];
      check("a_ready", 64'(a_ready), 64'(qa.size() < D));
      check("b_ready", 64'(b_ready), 64'(qb.size() < D));
      check("rf_en", 64'(rf_en), 64'(g >= 0));
      check("rf_rd", 64'(rf_rd), 64'(h.rd));
      check("rf_data", 64'(rf_data), 64'(h.data));
      check("pending", 64'(pending), 64'(pend));
      if (rf_en === 1'b1) n_wr++;
   endtask

   // called at a negedge: check, drive, advance model, one clock
   task automatic cycle(input bit av, input logic [4:0] ard,
                        input logic [W-1:0] ad,
                        input bit bv, input logic [4:0] brd,
                        input logic [W-1:0] bd,
                        output bit acc_a, output bit acc_b);
      int g;
      check_outputs();
      a_valid = av;
      a_rd    = ard;
      a_data  = ad;
      b_valid = bv;
      b_rd    = brd;
      b_data  = bd;
      acc_a = av && (qa.size() < D);
      acc_b = bv && (qb.size() < D);
      g = model_grant();
      if (g == 0) begin
         void'(qa.pop_front());
         last_b = 1'b0;
      end
      if (g == 1) begin
         void'(qb.pop_front());
         last_b = 1'b1;
      end
      if (acc_a && ard != 5'd0) qa.push_back(mk(ard, ad));
      if (acc_b && brd != 5'd0) qb.push_back(mk(brd, bd));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bit xa;
      bit xb;
      for (int i = 0; i < n; i++)
         cycle(0, 5'd0, '0, 0, 5'd0, '0, xa, xb);
   endtask

   task automatic do_reset();
      rst     = 1'b0;
      a_valid = 1'b0;
      b_valid = 1'b0;
      #1;
      check("rst rf_en", 64'(rf_en), 64'(0));
      check("rst rf_rd", 64'(rf_rd), 64'(0));
      check("rst rf_data", 64'(rf_data), 64'(0));
      check("rst pending", 64'(pending), 64'(0));
      check("rst a_ready", 64'(a_ready), 64'(0));
      check("rst b_ready", 64'(b_ready), 64'(0));
      qa.delete();
      qb.delete();
      last_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   // push la/lb in order, holding each entry until accepted
   task automatic run_lists(input int bound);
      int   ia;
      int   ib;
      int   c;
      bit   va;
      bit   vb;
      bit   xa;
      bit   xb;
      ent_t ea;
      ent_t eb;
      ia = 0;
      ib = 0;
      c  = 0;
      while ((ia < la.size() || ib < lb.size()) && c < bound) begin
         va = ia < la.size();
         vb = ib < lb.size();
         ea = '0;
         eb = '0;
         if (va) ea = la[ia];
         if (vb) eb = lb[ib];
         cycle(va, ea.rd, ea.data, vb, eb.rd, eb.data, xa, xb);
         if (xa) ia++;
         if (xb) ib++;
         c++;
      end
      check("list accepted", 64'(ia + ib),
            64'(la.size() + lb.size()));
   endtask

   initial begin
      bit           ha;
      bit           hb;
      bit           va;
      bit           vb;
      bit           xa;
      bit           xb;
      logic [4:0]   ra;
      logic [4:0]   rb;
      logic [W-1:0] da;
      logic [W-1:0] db;
      int           w0;

      @(negedge clk);
      do_reset();

      // single A write reaches the port one cycle later
      cycle(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, '0, xa, xb);
      check("t1 rf_data", 64'(rf_data), 64'h0000_0000_DEADBEEF);
      idle(3);

      // both sources stream 8 distinct writes
      la.delete();
      lb.delete();
      for (int k = 0; k < 8; k++) begin
         la.push_back(mk(5'(1 + k), 32'hA000_0000 + k));
         lb.push_back(mk(5'(16 + k), 32'hB000_0000 + k));
      end
      w0 = n_wr;
      run_lists(60);
      idle(8);
      check("t2 write count", 64'(n_wr - w0), 64'(16));

      // B overflows depth while A stays busy
      la.delete();
      lb.delete();
      for (int k = 0; k < 6; k++)
         la.push_back(mk(5'(1 + k), 32'hC0 + k));
      for (int k = 0; k < 3; k++)
         lb.push_back(mk(5'(20 + k), 32'hD0 + k));
      run_lists(40);
      idle(8);

      // x0 write is accepted and discarded
      cycle(1, 5'd0, 32'h1234, 0, 5'd0, '0, xa, xb);
      check("t4 x0 accept", 64'(xa), 64'(1));
      idle(3);

      // same rd from both sources
      la.delete();
      lb.delete();
      la.push_back(mk(5'd7, 32'h77));
      lb.push_back(mk(5'd7, 32'h88));
      w0 = n_wr;
      run_lists(10);
      idle(4);
      check("t5 write count", 64'(n_wr - w0), 64'(2));

      // reset with both FIFOs loaded
      for (int k = 0; k < 3; k++)
         cycle(1, 5'(3 + k), 32'hE0 + k,
               1, 5'(10 + k), 32'hF0 + k, xa, xb);
      check("t6 queued", 64'(qa.size() + qb.size() >= 3), 64'(1));
      do_reset();
      idle(4);

      // random traffic with producer hold and occasional reset
      ha = 0;
      hb = 0;
      va = 0;
      vb = 0;
      ra = '0;
      rb = '0;
      da = '0;
      db = '0;
      for (int c = 0; c < 3000; c++) begin
         if (!ha) begin
            va = $urandom_range(0, 3) != 0;
            ra = ($urandom_range(0, 3) == 0)
                 ? 5'($urandom) : 5'($urandom_range(0, 7));
            da = $urandom;
         end
         if (!hb) begin
            vb = $urandom_range(0, 3) != 0;
            rb = ($urandom_range(0, 3) == 0)
                 ? 5'($urandom) : 5'($urandom_range(0, 7));
            db = $urandom;
         end
         if ($urandom_range(0, 249) == 0) begin
            do_reset();
            ha = 0;
            hb = 0;
         end else begin
            cycle(va, ra, da, vb, rb, db, xa, xb);
            ha = va && !xa;
            hb = vb && !xb;
         end
      end
      idle(6);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
